// File: rtl/pc_sequencer_if.sv
// Handshake/bus bundle for pc_sequencer: control inputs, targets and PC outputs.
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             load;
    logic             branch;
    logic             z_flag;
    logic [15:0]      imm16;
    logic             jump;
    logic [25:0]      jump_index;
    logic             jump_reg;
    logic [WIDTH-1:0] reg_target;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic             in_slot;
    logic             align_err;
    logic             slot_err;

    modport master (
        output load, branch, z_flag, imm16, jump,
        output jump_index, jump_reg, reg_target,
        input  pc, pc_plus4, in_slot, align_err, slot_err
    );

    modport slave (
        input  load, branch, z_flag, imm16, jump,
        input  jump_index, jump_reg, reg_target,
        output pc, pc_plus4, in_slot, align_err, slot_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// MIPS program-counter unit: PC register, incrementer, branch/jump targets
// and an optional one-instruction branch-delay-slot sequencer.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               INC          = 4,
    parameter bit               DELAY_SLOT   = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);
    typedef enum logic {RUN, SLOT} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_target;
    logic             r_in_slot;
    logic             r_align_err;
    logic             r_slot_err;

    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_br_off;
    logic [WIDTH-1:0] w_br_tgt;
    logic [WIDTH-1:0] w_j_tgt;
    logic [WIDTH-1:0] w_jr_tgt;
    logic [WIDTH-1:0] w_target;
    logic             w_taken;
    logic             w_req;
    logic             w_misalign;

    assign w_pc_plus4 = r_pc + WIDTH'(INC);
    assign w_br_off   = {{(WIDTH-18){bus.imm16[15]}},
                         bus.imm16, 2'b00};
    assign w_br_tgt   = w_pc_plus4 + w_br_off;
    assign w_j_tgt    = {w_pc_plus4[WIDTH-1:28],
                         bus.jump_index, 2'b00};
    assign w_jr_tgt   = {bus.reg_target[WIDTH-1:2], 2'b00};
    assign w_taken    = bus.branch & bus.z_flag;
    assign w_req      = bus.jump_reg | bus.jump | w_taken;
    assign w_misalign = bus.jump_reg &
                        (|bus.reg_target[1:0]);

    // Overlapping requests resolve jump_reg > jump > branch.
    always_comb begin
        w_target = w_br_tgt;
        priority case (1'b1)
            bus.jump_reg: w_target = w_jr_tgt;
            bus.jump:     w_target = w_j_tgt;
            default:      w_target = w_br_tgt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_pc        <= RESET_VECTOR;
            r_target    <= '0;
            r_in_slot   <= 1'b0;
            r_align_err <= 1'b0;
            r_slot_err  <= 1'b0;
        end else begin
            r_align_err <= 1'b0;
            if (bus.load) begin
                unique case (r_state)
                    RUN: begin
                        if (w_req) begin
                            r_align_err <= w_misalign;
                            if (DELAY_SLOT) begin
                                r_target  <= w_target;
                                r_pc      <= w_pc_plus4;
                                r_state   <= SLOT;
                                r_in_slot <= 1'b1;
                            end else begin
                                r_pc <= w_target;
                            end
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                    end
                    SLOT: begin
                        // A second redirect cannot be honoured here.
                        r_pc      <= r_target;
                        r_state   <= RUN;
                        r_in_slot <= 1'b0;
                        if (w_req)
                            r_slot_err <= 1'b1;
                    end
                    default: begin
                        r_state <= RUN;
                    end
                endcase
            end
        end
    end

    assign bus.pc        = r_pc;
    assign bus.pc_plus4  = w_pc_plus4;
    assign bus.in_slot   = r_in_slot;
    assign bus.align_err = r_align_err;
    assign bus.slot_err  = r_slot_err;
endmodule
